// File: rtl/seg_scan_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_sched_pkg
// Description : Shared types and helpers for the segment scan scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_sched_pkg;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    localparam int   c_MAX_DIGITS = 8;
    localparam logic SEG_BLANK    = 1'b0;

    function automatic logic [c_MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
        logic [c_MAX_DIGITS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_scheduler_if
// Description : Valid/ready digit write port of the segment scan scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_scheduler_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DW         = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [$clog2(NUM_DIGITS)-1:0] in_addr;
    logic [DW-1:0]                 in_data;

    modport master (output in_valid, output in_addr, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_addr, input  in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/seg_scan_scheduler_bank.sv
`default_nettype none
// ============================================================================
// Module      : seg_sched_bank
// Description : Shadow/active digit value banks with frame-boundary commit.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_sched_bank #(
    parameter int NUM_DIGITS = 4,
    parameter int DW         = 8
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic                          i_wr_en,
    input  wire logic [$clog2(NUM_DIGITS)-1:0] i_wr_addr,
    input  wire logic [DW-1:0]                 i_wr_data,
    input  wire logic                          i_commit,
    input  wire logic [$clog2(NUM_DIGITS)-1:0] i_rd_idx,
    output logic      [DW-1:0]                 o_rd_data
);

    logic [DW-1:0] r_shadow [NUM_DIGITS];
    logic [DW-1:0] r_active [NUM_DIGITS];
    logic          r_dirty;
    logic          w_wr_hit;

    // Out-of-range addresses complete the handshake but touch nothing.
    assign w_wr_hit = i_wr_en && (int'(i_wr_addr) < NUM_DIGITS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_dirty <= 1'b0;
        end else begin
            if (i_commit && r_dirty) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_dirty <= 1'b0;
            end
            // A write on the commit edge is newer than the commit, so it keeps dirty set.
            if (w_wr_hit) begin
                r_shadow[i_wr_addr] <= i_wr_data;
                r_dirty             <= 1'b1;
            end
        end
    end

    // Bypass so the first digit of a committing frame sees the new value.
    assign o_rd_data = (i_commit && r_dirty) ? r_shadow[i_rd_idx] : r_active[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_scheduler
// Description : Multiplexed digit scanner sharing one segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_scheduler
    import seg_sched_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DW           = 8,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  enable,
    seg_scan_scheduler_if.slave        wr,
    output logic      [DW-1:0]         dec_in,
    input  wire logic [DW-1:0]         dec_seg,
    output logic      [DW-1:0]         seg_out,
    output logic      [NUM_DIGITS-1:0] digit_en,
    output logic                       frame_tick
);

    localparam int c_IW   = $clog2(NUM_DIGITS);
    localparam int c_CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_CW   = (c_CMAX > 1) ? $clog2(c_CMAX) : 1;

    localparam logic [c_CW-1:0] c_DWELL_LAST = c_CW'(DWELL_CYCLES - 1);
    localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'(BLANK_CYCLES - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(NUM_DIGITS - 1);

    state_t            r_state, w_state_nxt;
    logic [c_IW-1:0]   r_idx, w_idx_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [DW-1:0]     r_dec_in, r_seg_out;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic              r_frame_tick;
    logic              w_blank_done, w_dwell_done, w_wrap;
    logic              w_enter_blank, w_commit, w_start_drive;
    logic [DW-1:0]     w_rd_data;

    assign w_blank_done = (r_state == S_BLANK) && (r_cnt == c_BLANK_LAST);
    assign w_dwell_done = (r_state == S_DRIVE) && (r_cnt == c_DWELL_LAST);
    assign w_wrap       = w_dwell_done && (r_idx == c_IDX_LAST);

    // Stall writes for the cycle ahead of a wrap commit to avoid a same-edge race.
    assign wr.in_ready  = !w_wrap;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (!enable) begin
            w_state_nxt = S_OFF;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt = S_BLANK;
                    w_idx_nxt   = '0;
                end
                S_BLANK: begin
                    if (w_blank_done) w_state_nxt = S_DRIVE;
                end
                S_DRIVE: begin
                    if (w_dwell_done) begin
                        w_state_nxt = S_BLANK;
                        w_idx_nxt   = w_wrap ? '0 : r_idx + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    assign w_enter_blank = (w_state_nxt == S_BLANK) && (r_state != S_BLANK);
    assign w_commit      = w_enter_blank && (w_idx_nxt == '0);
    assign w_start_drive = (r_state == S_BLANK) && (w_state_nxt == S_DRIVE);

    seg_sched_bank #(
        .NUM_DIGITS (NUM_DIGITS),
        .DW         (DW)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (wr.in_valid && wr.in_ready),
        .i_wr_addr  (wr.in_addr),
        .i_wr_data  (wr.in_data),
        .i_commit   (w_commit),
        .i_rd_idx   (w_idx_nxt),
        .o_rd_data  (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_OFF;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_dec_in     <= '0;
            r_seg_out    <= '0;
            r_digit_en   <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if ((w_state_nxt != r_state) || (w_state_nxt == S_OFF)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_enter_blank) begin
                r_dec_in <= w_rd_data;
            end
            if (w_start_drive) begin
                r_seg_out  <= dec_seg;
                r_digit_en <= NUM_DIGITS'(onehot(3'(r_idx)));
            end else if (w_state_nxt != S_DRIVE) begin
                r_seg_out  <= {DW{SEG_BLANK}};
                r_digit_en <= '0;
            end
            r_frame_tick <= w_wrap && enable;
        end
    end

    assign dec_in     = r_dec_in;
    assign seg_out    = r_seg_out;
    assign digit_en   = r_digit_en;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_scheduler
// Description : Directed self-checking bench for seg_scan_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       enable5 = 1'b0;
    logic [7:0] dec_in, dec_seg, seg_out;
    logic [3:0] digit_en;
    logic       frame_tick;
    logic [7:0] dec_in5, dec_seg5, seg_out5;
    logic [4:0] digit_en5;
    logic       frame_tick5;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_scan_scheduler_if #(.NUM_DIGITS(4), .DW(8)) wr_if ();
    seg_scan_scheduler_if #(.NUM_DIGITS(5), .DW(8)) wr5_if ();

    assign dec_seg  = ~dec_in;
    assign dec_seg5 = ~dec_in5;

    seg_scan_scheduler #(
        .NUM_DIGITS(4), .DW(8), .DWELL_CYCLES(4), .BLANK_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr_if.slave),
        .dec_in(dec_in), .dec_seg(dec_seg), .seg_out(seg_out),
        .digit_en(digit_en), .frame_tick(frame_tick)
    );

    seg_scan_scheduler #(
        .NUM_DIGITS(5), .DW(8), .DWELL_CYCLES(1), .BLANK_CYCLES(1)
    ) dut5 (
        .clk(clk), .rst_n(rst_n), .enable(enable5), .wr(wr5_if.slave),
        .dec_in(dec_in5), .dec_seg(dec_seg5), .seg_out(seg_out5),
        .digit_en(digit_en5), .frame_tick(frame_tick5)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_drive(input string tag, input logic [3:0] en, input logic [7:0] seg);
        check_vec({tag, "_en"}, digit_en, en);
        check_vec({tag, "_seg"}, seg_out, seg);
    endtask

    task automatic write_req(input logic [1:0] addr, input logic [7:0] data);
        int guard;
        guard           = 0;
        wr_if.in_valid  = 1'b1;
        wr_if.in_addr   = addr;
        wr_if.in_data   = data;
        while (!wr_if.in_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        check_vec("wr_ready", wr_if.in_ready, 1);
        @(negedge clk);
        wr_if.in_valid = 1'b0;
    endtask

    task automatic write5(input logic [2:0] addr, input logic [7:0] data);
        wr5_if.in_valid = 1'b1;
        wr5_if.in_addr  = addr;
        wr5_if.in_data  = data;
        check_vec("wr5_ready", wr5_if.in_ready, 1);
        @(negedge clk);
        wr5_if.in_valid = 1'b0;
    endtask

    task automatic sync_frame();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!frame_tick && guard < 30);
        check_vec("sync_tick", frame_tick, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        int pos, ph, k;
        logic [3:0] en_e;

        wr_if.in_valid  = 1'b0;
        wr_if.in_addr   = '0;
        wr_if.in_data   = '0;
        wr5_if.in_valid = 1'b0;
        wr5_if.in_addr  = '0;
        wr5_if.in_data  = '0;

        // Reset values
        step(3);
        check_vec("rst_digit_en", digit_en, 0);
        check_vec("rst_seg_out", seg_out, 0);
        check_vec("rst_dec_in", dec_in, 0);
        check_vec("rst_frame_tick", frame_tick, 0);
        check_vec("rst_in_ready", wr_if.in_ready, 1);
        rst_n = 1'b1;
        step(2);
        check_vec("off_digit_en", digit_en, 0);

        // Two free-running frames with empty banks
        enable = 1'b1;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            pos  = c % 24;
            ph   = pos % 6;
            en_e = (ph >= 2) ? 4'(1 << (pos / 6)) : 4'd0;
            check_vec($sformatf("scan_en_c%0d", c), digit_en, en_e);
            check_vec($sformatf("scan_seg_c%0d", c), seg_out, (ph >= 2) ? 8'hFF : 8'h00);
            check_vec($sformatf("scan_tick_c%0d", c), frame_tick, (pos == 0 && c != 0));
            check_vec($sformatf("scan_ready_c%0d", c), wr_if.in_ready, (pos != 23));
        end

        // Mid-frame write only shows from the next frame
        sync_frame();
        write_req(2'd2, 8'h35);
        step(13);
        expect_drive("a_d2_old", 4'b0100, 8'hFF);
        step(8);
        check_vec("a_ready_f22", wr_if.in_ready, 1);
        step(1);
        check_vec("a_ready_f23", wr_if.in_ready, 0);
        step(1);
        check_vec("b_tick", frame_tick, 1);
        step(14);
        expect_drive("b_d2_new", 4'b0100, 8'hCA);
        check_vec("b_d2_dec_in", dec_in, 8'h35);

        // Last write to the same address wins
        write_req(2'd1, 8'h10);
        write_req(2'd1, 8'h22);
        step(16);
        expect_drive("c_d1", 4'b0010, 8'hDD);
        step(6);
        expect_drive("c_d2", 4'b0100, 8'hCA);

        // Enable drop during digit 1 with a pending write, then restart
        step(12);
        write_req(2'd0, 8'h0F);
        step(6);
        expect_drive("d_d1", 4'b0010, 8'hDD);
        enable = 1'b0;
        step(1);
        expect_drive("off_drop", 4'b0000, 8'h00);
        for (int c = 0; c < 20; c++) begin
            check_vec($sformatf("off_tick_%0d", c), frame_tick, 0);
            step(1);
        end
        check_vec("off_ready", wr_if.in_ready, 1);
        enable = 1'b1;
        step(1);
        check_vec("re_r0_en", digit_en, 0);
        check_vec("re_r0_tick", frame_tick, 0);
        step(1);
        check_vec("re_r1_en", digit_en, 0);
        step(1);
        expect_drive("re_d0", 4'b0001, 8'hF0);
        check_vec("re_d0_dec_in", dec_in, 8'h0F);

        // Asynchronous reset mid-dwell
        step(1);
        rst_n = 1'b0;
        #1;
        expect_drive("arst", 4'b0000, 8'h00);
        step(1);
        rst_n = 1'b1;
        step(1);
        check_vec("q0_en", digit_en, 0);
        step(2);
        expect_drive("q_d0", 4'b0001, 8'hFF);
        check_vec("q_d0_dec_in", dec_in, 8'h00);
        step(6);
        expect_drive("q_d1", 4'b0010, 8'hFF);
        step(6);
        expect_drive("q_d2", 4'b0100, 8'hFF);

        // Continuous writes across a frame wrap
        step(6);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            wr_if.in_valid = 1'b1;
            wr_if.in_addr  = 2'(k % 4);
            wr_if.in_data  = 8'(8'h40 + k);
            check_vec($sformatf("burst_ready_%0d", i), wr_if.in_ready, (i != 3));
            if (i == 4) check_vec("burst_tick", frame_tick, 1);
            if (wr_if.in_ready) k++;
            @(negedge clk);
        end
        wr_if.in_valid = 1'b0;
        check_vec("burst_count", k, 7);
        expect_drive("s_d0", 4'b0001, 8'hBF);
        step(4);
        expect_drive("s_d1", 4'b0010, 8'hBE);
        step(6);
        expect_drive("s_d2", 4'b0100, 8'hBD);
        step(6);
        expect_drive("s_d3", 4'b1000, 8'hFF);
        step(6);
        expect_drive("t_d0", 4'b0001, 8'hBB);
        step(6);
        expect_drive("t_d1", 4'b0010, 8'hBA);
        step(6);
        expect_drive("t_d2", 4'b0100, 8'hB9);
        step(6);
        expect_drive("t_d3", 4'b1000, 8'hBC);

        // Out-of-range addresses on a five-digit instance
        write5(3'd5, 8'h77);
        check_vec("oor5_dirty", dut5.u_bank.r_dirty, 0);
        write5(3'd7, 8'h77);
        check_vec("oor7_dirty", dut5.u_bank.r_dirty, 0);
        write5(3'd4, 8'h12);
        check_vec("in4_dirty", dut5.u_bank.r_dirty, 1);
        enable5 = 1'b1;
        step(2);
        check_vec("n5_d0_en", digit_en5, 5'b00001);
        check_vec("n5_d0_seg", seg_out5, 8'hFF);
        step(8);
        check_vec("n5_d4_en", digit_en5, 5'b10000);
        check_vec("n5_d4_seg", seg_out5, 8'hED);
        step(1);
        check_vec("n5_tick", frame_tick5, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
